// File: rtl/mem_access_pkg.sv
// Shared definitions for the core-side AXI4-Lite load/store master:
// RV32 width codes, AXI response codes, FSM states and request legality check.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WREQ,
    WRESP,
    RESP
  } state_t;

  // 1 when the request must be rejected without touching the bus
  function automatic logic req_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_master_lane.sv
// Combinational byte-lane steering shared by load and store paths:
// store data/strobe shifted to the addressed lane, load data extracted and extended.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata
);

  logic [4:0]  shamt;
  logic [31:0] lane;

  always_comb begin
    shamt = {addr_lo, 3'b000};
    wdata = st_data << shamt;
    lane  = ld_data >> shamt;
    wstrb = 4'b0000;
    rdata = 32'h0;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << addr_lo;
        rdata = {{24{lane[7]}}, lane[7:0]};
      end
      F3_BU: begin
        wstrb = 4'b0001 << addr_lo;
        rdata = {24'h0, lane[7:0]};
      end
      F3_H: begin
        wstrb = 4'b0011 << addr_lo;
        rdata = {{16{lane[15]}}, lane[15:0]};
      end
      F3_HU: begin
        wstrb = 4'b0011 << addr_lo;
        rdata = {16'h0, lane[15:0]};
      end
      F3_W: begin
        wstrb = 4'b1111;
        rdata = lane;
      end
      default: begin
        wstrb = 4'b0000;
        rdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// Core-side AXI4-Lite master: one RV32 load/store becomes one AXI read or write, one outstanding.
// Optional MEM_ACCESS_PERF_EN adds perf_loads/perf_stores completion counters.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
`ifdef MEM_ACCESS_PERF_EN
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  output logic [2:0]        axi_arprot,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [2:0]        axi_awprot,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [3:0]        axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready
);

  state_t            state;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic [3:0]  al_wstrb;
  logic        aw_pend;
  logic        w_pend;

  mem_lane_align u_align (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .st_data (wdata_q),
    .ld_data (axi_rdata),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb),
    .rdata   (al_rdata)
  );

  // Each write channel stays valid until its own handshake
  assign aw_pend = axi_awvalid & ~axi_awready;
  assign w_pend  = axi_wvalid  & ~axi_wready;

  assign axi_araddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign axi_awaddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign axi_arprot = 3'b000;
  assign axi_awprot = 3'b000;
  assign axi_wdata  = al_wdata;
  assign axi_wstrb  = axi_wvalid ? al_wstrb : 4'b0000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            store_q   <= req_store;
            f3_q      <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            if (req_bad(req_funct3, req_addr[1:0])) begin
              state <= RESP;
            end else if (req_store) begin
              state       <= WREQ;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
            end else begin
              state       <= RADDR;
              axi_arvalid <= 1'b1;
              axi_rready  <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            // Slave may return data in the same cycle it takes the address
            if (axi_rvalid) begin
              axi_rready <= 1'b0;
              rsp_valid  <= 1'b1;
              rsp_rdata  <= al_rdata;
              rsp_err    <= (axi_rresp != RESP_OKAY);
              state      <= RESP;
            end else begin
              state <= RDATA;
            end
          end
        end
        RDATA: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= al_rdata;
            rsp_err    <= (axi_rresp != RESP_OKAY);
            state      <= RESP;
          end
        end
        WREQ: begin
          axi_awvalid <= aw_pend;
          axi_wvalid  <= w_pend;
          if (!aw_pend && !w_pend) begin
            axi_bready <= 1'b1;
            state      <= WRESP;
          end
        end
        WRESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_err    <= (axi_bresp != RESP_OKAY);
            state      <= RESP;
          end
        end
        RESP: begin
          // Rejected requests arrive here with no pulse yet and spend one extra cycle
          if (rsp_valid) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  logic load_done;
  logic store_done;

  assign load_done  = ((state == RDATA) && axi_rvalid) ||
                      ((state == RADDR) && axi_arready && axi_rvalid);
  assign store_done = (state == WRESP) && axi_bvalid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_loads  <= 32'h0;
      perf_stores <= 32'h0;
    end else begin
      if (load_done)  perf_loads  <= perf_loads + 32'd1;
      if (store_done) perf_stores <= perf_stores + 32'd1;
    end
  end
`endif

endmodule
